// File: rtl/axi_burst_slave_mem.sv
// AXI4 INCR burst slave in front of a word-addressed on-chip memory.
// Serves one write or read burst at a time and reports OKAY/SLVERR per burst or beat.
module axi_burst_slave_mem #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64,
    parameter int DEPTH  = 256
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic [ADDR_W-1:0]     s_axi_awaddr,
    input  logic [7:0]            s_axi_awlen,
    input  logic [2:0]            s_axi_awsize,
    input  logic [1:0]            s_axi_awburst,
    input  logic                  s_axi_awvalid,
    output logic                  s_axi_awready,
    input  logic [DATA_W-1:0]     s_axi_wdata,
    input  logic [DATA_W/8-1:0]   s_axi_wstrb,
    input  logic                  s_axi_wlast,
    input  logic                  s_axi_wvalid,
    output logic                  s_axi_wready,
    output logic [1:0]            s_axi_bresp,
    output logic                  s_axi_bvalid,
    input  logic                  s_axi_bready,
    input  logic [ADDR_W-1:0]     s_axi_araddr,
    input  logic [7:0]            s_axi_arlen,
    input  logic [2:0]            s_axi_arsize,
    input  logic [1:0]            s_axi_arburst,
    input  logic                  s_axi_arvalid,
    output logic                  s_axi_arready,
    output logic [DATA_W-1:0]     s_axi_rdata,
    output logic [1:0]            s_axi_rresp,
    output logic                  s_axi_rlast,
    output logic                  s_axi_rvalid,
    input  logic                  s_axi_rready
);
    localparam int BYTES = DATA_W / 8;
    localparam int SH    = $clog2(BYTES);
    localparam int WA    = ADDR_W - SH;
    localparam int MA    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {IDLE, WDATA, WRESP, RDATA} state_t;

    state_t            state;
    logic [WA-1:0]     addr;
    logic [7:0]        len;
    logic [7:0]        cnt;
    logic              err;
    logic              pend;
    logic [WA-1:0]     pend_addr;
    logic [7:0]        pend_len;
    logic              pend_err;
    logic [DATA_W-1:0] mem [DEPTH];

    function automatic logic in_range(input logic [WA-1:0] a);
        return a < WA'(DEPTH);
    endfunction

    function automatic logic [DATA_W-1:0] read_word(input logic [WA-1:0] a);
        return in_range(a) ? mem[a[MA-1:0]] : '0;
    endfunction

    logic          aw_hs, ar_hs, w_fire, r_fire, w_last_beat, w_beat_err, mem_we;
    logic          aw_err, ar_err;
    logic [WA-1:0] aw_word, ar_word, nb_addr;
    logic [WA-1:0] rs_addr;
    logic [7:0]    rs_len;
    logic          rs_err;

    assign aw_hs       = (state == IDLE) && s_axi_awvalid && s_axi_awready;
    assign ar_hs       = (state == IDLE) && s_axi_arvalid && s_axi_arready;
    assign w_fire      = (state == WDATA) && s_axi_wvalid && s_axi_wready;
    assign r_fire      = (state == RDATA) && s_axi_rvalid && s_axi_rready;
    assign w_last_beat = (cnt == len);
    assign w_beat_err  = !in_range(addr) || (s_axi_wlast != w_last_beat);
    assign mem_we      = w_fire && in_range(addr) && !err;
    assign aw_err      = (s_axi_awsize != 3'(SH)) || (s_axi_awburst != 2'b01);
    assign ar_err      = (s_axi_arsize != 3'(SH)) || (s_axi_arburst != 2'b01);
    assign aw_word     = s_axi_awaddr[ADDR_W-1:SH];
    assign ar_word     = s_axi_araddr[ADDR_W-1:SH];
    assign nb_addr     = addr + WA'(1);

    // A read that tied with a write is parked in pend_* and started straight from WRESP.
    assign rs_addr = (state == WRESP) ? pend_addr : ar_word;
    assign rs_len  = (state == WRESP) ? pend_len  : s_axi_arlen;
    assign rs_err  = (state == WRESP) ? pend_err  : ar_err;

    generate
        if (SH > 0) begin : g_unused
            logic unused_addr_bits;
            assign unused_addr_bits = ^{s_axi_awaddr[SH-1:0], s_axi_araddr[SH-1:0]};
        end
    endgenerate

    always_ff @(posedge aclk) begin
        if (mem_we) begin
            for (int i = 0; i < BYTES; i++) begin
                if (s_axi_wstrb[i]) mem[addr[MA-1:0]][i*8 +: 8] <= s_axi_wdata[i*8 +: 8];
            end
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state         <= IDLE;
            addr          <= '0;
            len           <= '0;
            cnt           <= '0;
            err           <= 1'b0;
            pend          <= 1'b0;
            pend_addr     <= '0;
            pend_len      <= '0;
            pend_err      <= 1'b0;
            s_axi_awready <= 1'b0;
            s_axi_arready <= 1'b0;
            s_axi_wready  <= 1'b0;
            s_axi_bvalid  <= 1'b0;
            s_axi_bresp   <= RESP_OKAY;
            s_axi_rvalid  <= 1'b0;
            s_axi_rlast   <= 1'b0;
            s_axi_rresp   <= RESP_OKAY;
            s_axi_rdata   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    s_axi_awready <= 1'b1;
                    s_axi_arready <= !s_axi_awvalid;
                    if (aw_hs) begin
                        state         <= WDATA;
                        addr          <= aw_word;
                        len           <= s_axi_awlen;
                        cnt           <= '0;
                        err           <= aw_err;
                        s_axi_awready <= 1'b0;
                        s_axi_arready <= 1'b0;
                        s_axi_wready  <= 1'b1;
                        if (ar_hs) begin
                            pend      <= 1'b1;
                            pend_addr <= ar_word;
                            pend_len  <= s_axi_arlen;
                            pend_err  <= ar_err;
                        end
                    end else if (ar_hs) begin
                        state         <= RDATA;
                        addr          <= rs_addr;
                        len           <= rs_len;
                        cnt           <= '0;
                        err           <= rs_err;
                        s_axi_awready <= 1'b0;
                        s_axi_arready <= 1'b0;
                        s_axi_rvalid  <= 1'b1;
                        s_axi_rdata   <= read_word(rs_addr);
                        s_axi_rresp   <= (rs_err || !in_range(rs_addr)) ? RESP_SLVERR : RESP_OKAY;
                        s_axi_rlast   <= (rs_len == 8'd0);
                    end
                end
                WDATA: begin
                    if (w_fire) begin
                        addr <= nb_addr;
                        cnt  <= cnt + 8'd1;
                        if (w_beat_err) err <= 1'b1;
                        if (w_last_beat) begin
                            state        <= WRESP;
                            s_axi_wready <= 1'b0;
                            s_axi_bvalid <= 1'b1;
                            s_axi_bresp  <= (err || w_beat_err) ? RESP_SLVERR : RESP_OKAY;
                        end
                    end
                end
                WRESP: begin
                    if (s_axi_bready) begin
                        s_axi_bvalid <= 1'b0;
                        s_axi_bresp  <= RESP_OKAY;
                        if (pend) begin
                            pend         <= 1'b0;
                            state        <= RDATA;
                            addr         <= rs_addr;
                            len          <= rs_len;
                            cnt          <= '0;
                            err          <= rs_err;
                            s_axi_rvalid <= 1'b1;
                            s_axi_rdata  <= read_word(rs_addr);
                            s_axi_rresp  <= (rs_err || !in_range(rs_addr)) ? RESP_SLVERR : RESP_OKAY;
                            s_axi_rlast  <= (rs_len == 8'd0);
                        end else begin
                            state         <= IDLE;
                            s_axi_awready <= 1'b1;
                            s_axi_arready <= !s_axi_awvalid;
                        end
                    end
                end
                RDATA: begin
                    if (r_fire) begin
                        if (s_axi_rlast) begin
                            state         <= IDLE;
                            s_axi_rvalid  <= 1'b0;
                            s_axi_rlast   <= 1'b0;
                            s_axi_rresp   <= RESP_OKAY;
                            s_axi_rdata   <= '0;
                            s_axi_awready <= 1'b1;
                            s_axi_arready <= !s_axi_awvalid;
                        end else begin
                            addr        <= nb_addr;
                            cnt         <= cnt + 8'd1;
                            s_axi_rdata <= read_word(nb_addr);
                            s_axi_rresp <= (err || !in_range(nb_addr)) ? RESP_SLVERR : RESP_OKAY;
                            s_axi_rlast <= ((cnt + 8'd1) == len);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_axi_burst_slave_mem.sv
// Self-checking bench for axi_burst_slave_mem: directed bursts plus randomized traffic
// compared against a byte-array memory model.
module tb_axi_burst_slave_mem;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 64;
    localparam int DEPTH  = 256;
    localparam int BYTES  = DATA_W / 8;
    localparam int SH     = 3;
    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    logic                aclk, aresetn;
    logic [ADDR_W-1:0]   awaddr, araddr;
    logic [7:0]          awlen, arlen;
    logic [2:0]          awsize, arsize;
    logic [1:0]          awburst, arburst;
    logic                awvalid, awready, arvalid, arready;
    logic [DATA_W-1:0]   wdata, rdata;
    logic [BYTES-1:0]    wstrb;
    logic                wlast, wvalid, wready;
    logic [1:0]          bresp, rresp;
    logic                bvalid, bready, rlast, rvalid, rready;

    axi_burst_slave_mem #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .s_axi_awaddr(awaddr), .s_axi_awlen(awlen), .s_axi_awsize(awsize), .s_axi_awburst(awburst),
        .s_axi_awvalid(awvalid), .s_axi_awready(awready),
        .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wlast(wlast), .s_axi_wvalid(wvalid),
        .s_axi_wready(wready),
        .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
        .s_axi_araddr(araddr), .s_axi_arlen(arlen), .s_axi_arsize(arsize), .s_axi_arburst(arburst),
        .s_axi_arvalid(arvalid), .s_axi_arready(arready),
        .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rlast(rlast), .s_axi_rvalid(rvalid),
        .s_axi_rready(rready)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    int               n_checks = 0;
    int               n_fail   = 0;
    logic [7:0]       ref_bytes [DEPTH*BYTES];
    time              b_time, first_r_time;
    logic [DATA_W-1:0] dq[$];
    logic [BYTES-1:0]  sq[$];
    logic [1:0]        resp;
    logic [DATA_W-1:0] last_data, d1;
    bit                ok;

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: observed %h, expected %h", tag, actual, expected);
        end
    endtask

    function automatic logic [DATA_W-1:0] ref_word(input longint wi);
        logic [DATA_W-1:0] w;
        w = '0;
        if (wi < DEPTH)
            for (int b = 0; b < BYTES; b++) w[b*8 +: 8] = ref_bytes[wi*BYTES + b];
        return w;
    endfunction

    // Full write burst: AW, data beats (optionally one early wlast), then B with random stall.
    task automatic axi_write(input logic [ADDR_W-1:0] addr, input int len, input logic [2:0] size,
                             input logic [1:0] burst, input int bad_beat,
                             input logic [DATA_W-1:0] d[$], input logic [BYTES-1:0] s[$],
                             output logic [1:0] r);
        bit got, err_m;
        longint wi;
        int stall;
        r = 2'bxx;
        @(posedge aclk); #1;
        err_m = (size != 3'(SH)) || (burst != 2'b01);
        awaddr = addr; awlen = 8'(len); awsize = size; awburst = burst; awvalid = 1'b1;
        got = 0;
        for (int c = 0; c < 1000; c++) begin
            @(negedge aclk);
            if (awready) begin got = 1; break; end
        end
        @(posedge aclk); #1;
        awvalid = 1'b0;
        if (!got) begin checkOutput("aw_timeout", 0, 1); return; end
        for (int k = 0; k <= len; k++) begin
            wdata = d[k]; wstrb = s[k];
            wlast = (k == len) != (k == bad_beat);
            wvalid = 1'b1;
            got = 0;
            for (int c = 0; c < 1000; c++) begin
                @(negedge aclk);
                if (wready) begin got = 1; break; end
            end
            if (!got) begin checkOutput("w_timeout", 0, 1); wvalid = 1'b0; return; end
            wi = longint'(addr / BYTES) + k;
            if (!err_m && wi < DEPTH)
                for (int b = 0; b < BYTES; b++)
                    if (s[k][b]) ref_bytes[wi*BYTES + b] = d[k][b*8 +: 8];
            if (wi >= DEPTH || wlast != (k == len)) err_m = 1;
            @(posedge aclk); #1;
        end
        wvalid = 1'b0; wlast = 1'b0;
        bready = 1'b0;
        got = 0;
        for (int c = 0; c < 1000; c++) begin
            @(negedge aclk);
            if (bvalid) begin got = 1; break; end
        end
        if (!got) begin checkOutput("b_timeout", 0, 1); return; end
        r = bresp;
        stall = $urandom_range(0, 2);
        for (int i = 0; i < stall; i++) begin
            @(posedge aclk); #1;
            @(negedge aclk);
            checkOutput("bvalid_hold", bvalid, 1);
            checkOutput("bresp_hold", bresp, r);
        end
        @(posedge aclk); #1;
        bready = 1'b1;
        @(negedge aclk);
        checkOutput("bvalid_hs", bvalid, 1);
        @(posedge aclk);
        b_time = $time;
        #1 bready = 1'b0;
        @(negedge aclk);
        checkOutput("bvalid_drop", bvalid, 0);
        checkOutput("bresp", r, err_m ? SLVERR : OKAY);
    endtask

    // Read burst; rmode 0 = always ready, 1 = ready pattern 1,0,0, 2 = random ready.
    task automatic axi_read(input logic [ADDR_W-1:0] addr, input int len, input logic [2:0] size,
                            input logic [1:0] burst, input int rmode, output logic [DATA_W-1:0] ld);
        bit got, err_m, stalled, first;
        int n, cyc;
        longint wi;
        logic [DATA_W-1:0] held_d;
        logic held_l;
        logic [1:0] held_r;
        ld = '0; held_d = '0; held_l = 1'b0; held_r = 2'b00;
        @(posedge aclk); #1;
        err_m = (size != 3'(SH)) || (burst != 2'b01);
        araddr = addr; arlen = 8'(len); arsize = size; arburst = burst; arvalid = 1'b1;
        got = 0;
        for (int c = 0; c < 1000; c++) begin
            @(negedge aclk);
            if (arready) begin got = 1; break; end
        end
        @(posedge aclk); #1;
        arvalid = 1'b0;
        if (!got) begin checkOutput("ar_timeout", 0, 1); return; end
        n = 0; cyc = 0; stalled = 0; first = 1;
        while (n <= len && cyc < 4000) begin
            case (rmode)
                0:       rready = 1'b1;
                1:       rready = (cyc % 3 == 0);
                default: rready = 1'($urandom_range(0, 1));
            endcase
            @(negedge aclk);
            if (rvalid) begin
                if (first) begin first_r_time = $time; first = 0; end
                if (stalled) begin
                    checkOutput("rdata_hold", rdata, held_d);
                    checkOutput("rlast_hold", rlast, held_l);
                    checkOutput("rresp_hold", rresp, held_r);
                end
                if (rready) begin
                    wi = longint'(addr / BYTES) + n;
                    checkOutput("rdata", rdata, ref_word(wi));
                    checkOutput("rresp", rresp, (err_m || wi >= DEPTH) ? SLVERR : OKAY);
                    checkOutput("rlast", rlast, n == len);
                    ld = rdata;
                    n++;
                    stalled = 0;
                end else begin
                    stalled = 1; held_d = rdata; held_l = rlast; held_r = rresp;
                end
            end
            @(posedge aclk); #1;
            cyc++;
        end
        rready = 1'b0;
        if (n <= len) checkOutput("r_timeout", n, len + 1);
        else begin
            @(negedge aclk);
            checkOutput("rvalid_drop", rvalid, 0);
        end
    endtask

    task automatic applyStimulus(input int iters);
        int wi, len;
        logic [DATA_W-1:0] rd;
        logic [DATA_W-1:0] d[$];
        logic [BYTES-1:0]  s[$];
        logic [1:0] r;
        for (int it = 0; it < iters; it++) begin
            wi  = $urandom_range(0, DEPTH + 3);
            len = $urandom_range(0, 15);
            if ($urandom_range(0, 1) == 1) begin
                d = {}; s = {};
                for (int k = 0; k <= len; k++) begin
                    d.push_back({$urandom, $urandom});
                    s.push_back(BYTES'($urandom));
                end
                axi_write(ADDR_W'(wi * BYTES), len, 3'(SH), 2'b01, -1, d, s, r);
            end else begin
                axi_read(ADDR_W'(wi * BYTES), len, 3'(SH), 2'b01, 2, rd);
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        aresetn = 1'b0;
        awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 1'b0;
        araddr = '0; arlen = '0; arsize = '0; arburst = '0; arvalid = 1'b0;
        wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0; rready = 1'b0;
        b_time = 0; first_r_time = 0;
        repeat (3) @(posedge aclk);
        #1;
        checkOutput("rst_awready", awready, 0);
        checkOutput("rst_arready", arready, 0);
        checkOutput("rst_wready", wready, 0);
        checkOutput("rst_bvalid", bvalid, 0);
        checkOutput("rst_rvalid", rvalid, 0);
        checkOutput("rst_rdata", rdata, 0);
        @(negedge aclk);
        aresetn = 1'b1;

        // Fill the whole memory so every later read has a known expectation
        dq = {}; sq = {};
        for (int k = 0; k < DEPTH; k++) begin dq.push_back({$urandom, $urandom}); sq.push_back('1); end
        axi_write(0, DEPTH - 1, 3'(SH), 2'b01, -1, dq, sq, resp);
        checkOutput("fill_bresp", resp, OKAY);
        axi_read(0, DEPTH - 1, 3'(SH), 2'b01, 0, last_data);

        dq = '{64'h11, 64'h22, 64'h33, 64'h44};
        sq = '{8'hFF, 8'hFF, 8'hFF, 8'hFF};
        axi_write(0, 3, 3'(SH), 2'b01, -1, dq, sq, resp);
        checkOutput("t1_bresp", resp, OKAY);
        axi_read(0, 3, 3'(SH), 2'b01, 0, last_data);
        checkOutput("t1_last", last_data, 64'h44);

        dq = '{64'h0}; sq = '{8'hFF};
        axi_write(32'h8, 0, 3'(SH), 2'b01, -1, dq, sq, resp);
        dq = '{64'hFFFF_FFFF_FFFF_FFFF}; sq = '{8'h0F};
        axi_write(32'h8, 0, 3'(SH), 2'b01, -1, dq, sq, resp);
        axi_read(32'h8, 0, 3'(SH), 2'b01, 0, last_data);
        checkOutput("t2_merge", last_data, 64'h0000_0000_FFFF_FFFF);

        axi_read(32'h40, 7, 3'(SH), 2'b01, 1, last_data);

        // Same-cycle AW and AR: the write must finish before read data appears
        dq = '{64'hA5A5_0000_1111_2222, 64'h5A5A_3333_4444_5555}; sq = '{8'hFF, 8'hFF};
        fork
            axi_write(32'h80, 1, 3'(SH), 2'b01, -1, dq, sq, resp);
            axi_read(32'h80, 1, 3'(SH), 2'b01, 0, last_data);
        join
        checkOutput("t4_order", first_r_time > b_time, 1);
        checkOutput("t4_data", last_data, 64'h5A5A_3333_4444_5555);

        dq = '{{$urandom, $urandom}, {$urandom, $urandom}}; sq = '{8'hFF, 8'hFF};
        axi_write(ADDR_W'((DEPTH - 1) * BYTES), 1, 3'(SH), 2'b01, -1, dq, sq, resp);
        checkOutput("t5_edge_bresp", resp, SLVERR);
        axi_read(ADDR_W'((DEPTH - 1) * BYTES), 1, 3'(SH), 2'b01, 0, last_data);
        checkOutput("t5_edge_oob_data", last_data, 0);
        dq = '{{$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom}};
        sq = '{8'hFF, 8'hFF, 8'hFF};
        axi_write(32'h200, 2, 3'(SH), 2'b01, 0, dq, sq, resp);
        checkOutput("t5_wlast_bresp", resp, SLVERR);
        axi_read(32'h200, 2, 3'(SH), 2'b01, 2, last_data);

        dq = '{64'h1234}; sq = '{8'hFF};
        axi_write(32'h300, 0, 3'd2, 2'b01, -1, dq, sq, resp);
        checkOutput("badsize_bresp", resp, SLVERR);
        axi_read(32'h300, 1, 3'(SH), 2'b10, 0, last_data);

        // Reset in the middle of a 4-beat write, while beat 2 is offered
        @(posedge aclk); #1;
        awaddr = 32'h100; awlen = 8'd3; awsize = 3'(SH); awburst = 2'b01; awvalid = 1'b1;
        ok = 0;
        for (int c = 0; c < 100; c++) begin @(negedge aclk); if (awready) begin ok = 1; break; end end
        @(posedge aclk); #1;
        awvalid = 1'b0;
        checkOutput("t6_aw_accept", ok, 1);
        d1 = {$urandom, $urandom};
        wdata = d1; wstrb = '1; wlast = 1'b0; wvalid = 1'b1;
        ok = 0;
        for (int c = 0; c < 100; c++) begin @(negedge aclk); if (wready) begin ok = 1; break; end end
        checkOutput("t6_w1_accept", ok, 1);
        for (int b = 0; b < BYTES; b++) ref_bytes[32*BYTES + b] = d1[b*8 +: 8];
        @(posedge aclk); #1;
        wdata = {$urandom, $urandom};
        #2 aresetn = 1'b0;
        #1;
        checkOutput("t6_awready", awready, 0);
        checkOutput("t6_arready", arready, 0);
        checkOutput("t6_wready", wready, 0);
        checkOutput("t6_bvalid", bvalid, 0);
        checkOutput("t6_bresp", bresp, 0);
        checkOutput("t6_rvalid", rvalid, 0);
        wvalid = 1'b0;
        @(negedge aclk);
        aresetn = 1'b1;
        @(posedge aclk); #1;
        checkOutput("t6_awready_release", awready, 1);
        axi_read(32'h100, 1, 3'(SH), 2'b01, 0, last_data);

        applyStimulus(24);
        axi_read(0, DEPTH - 1, 3'(SH), 2'b01, 2, last_data);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
